// File: rtl/disp_mode_ctrl.sv
// Front-panel sequencer: view/edit FSM, edit timeout, stopwatch run flag and alarm ring timer.
// Optional snooze support is compiled in when DISP_SNOOZE_EN is defined.
module disp_mode_ctrl #(
    parameter int RING_SECS    = 30,
    parameter int EDIT_TIMEOUT = 10,
    parameter int SNOOZE_SECS  = 300
) (
    input  logic       signal,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_set,
    input  logic       key_inc,
    input  logic       tick_1hz,
    input  logic       alarm_en,
    input  logic [4:0] hour_true,
    input  logic [5:0] minute_true,
    input  logic [5:0] second_true,
    input  logic [4:0] hour_al,
    input  logic [5:0] minute_al,
    output logic       sw,
    output logic       alarm,
    output logic       sw_run,
    output logic       inc_hour,
    output logic       inc_minute,
    output logic       inc_sel,
    output logic       blink,
    output logic       ring,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        V_TIME = 3'd0, V_SW = 3'd1, V_AL = 3'd2, E_TH = 3'd3,
        E_TM   = 3'd4, E_AH = 3'd5, E_AM = 3'd6, S_BAD = 3'd7
    } state_t;

    localparam int TW = $clog2(EDIT_TIMEOUT + 1);
    localparam int RW = $clog2(RING_SECS + 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
    logic            ring_q, ring_d;
    logic            sw_q, sw_d, alarm_q, alarm_d, inc_sel_q, inc_sel_d;
    logic            sw_run_q, sw_run_d, blink_q, blink_d;
    logic            inc_hour_q, inc_hour_d, inc_minute_q, inc_minute_d;
    logic            key_any, match, consume, in_edit, next_edit;

`ifdef DISP_SNOOZE_EN
    localparam int SW_W = $clog2(SNOOZE_SECS + 1);
    logic [SW_W-1:0] snz_cnt_q, snz_cnt_d;
    logic            snz_act_q, snz_act_d;
`endif

    function automatic logic is_edit(input state_t s);
        return (s == E_TH) || (s == E_TM) || (s == E_AH) || (s == E_AM);
    endfunction

    // Edit states fall back to the view they were entered from.
    function automatic state_t view_of(input state_t s);
        case (s)
            E_TH, E_TM: return V_TIME;
            E_AH, E_AM: return V_AL;
            default:    return s;
        endcase
    endfunction

    assign key_any = key_mode | key_set | key_inc;
    assign match   = alarm_en && (hour_true == hour_al) && (minute_true == minute_al)
                     && (second_true == 6'd0) && tick_1hz;
    assign consume = ring_q | match;
    assign in_edit = is_edit(state_q);

    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        sw_run_d     = sw_run_q;
        inc_hour_d   = 1'b0;
        inc_minute_d = 1'b0;
        next_edit    = 1'b0;
        blink_d      = 1'b0;

        if (state_q == S_BAD) begin
            state_d = V_TIME;
        end else if (key_any && !consume) begin
            if (key_mode) begin
                case (state_q)
                    V_TIME:  state_d = V_SW;
                    V_SW:    state_d = V_AL;
                    V_AL:    state_d = V_TIME;
                    default: state_d = view_of(state_q);
                endcase
            end else if (key_set) begin
                case (state_q)
                    V_TIME:  state_d = E_TH;
                    E_TH:    state_d = E_TM;
                    E_TM:    state_d = V_TIME;
                    V_AL:    state_d = E_AH;
                    E_AH:    state_d = E_AM;
                    E_AM:    state_d = V_AL;
                    default: state_d = state_q;
                endcase
            end else begin
                case (state_q)
                    E_TH, E_AH: inc_hour_d   = 1'b1;
                    E_TM, E_AM: inc_minute_d = 1'b1;
                    V_SW:       sw_run_d     = ~sw_run_q;
                    default:    ;
                endcase
            end
        end else if (!key_any && in_edit && tick_1hz
                     && (to_cnt_q == TW'(EDIT_TIMEOUT - 1))) begin
            state_d = view_of(state_q);
        end

        if (key_any)
            to_cnt_d = '0;
        else if (in_edit && tick_1hz)
            to_cnt_d = to_cnt_q + TW'(1);

        next_edit = is_edit(state_d);
        if (next_edit) begin
            if (!in_edit) begin
                blink_d  = 1'b1;
                to_cnt_d = '0;
            end else begin
                blink_d = tick_1hz ? ~blink_q : blink_q;
            end
        end
    end

    assign sw_d      = (state_d == V_SW);
    assign alarm_d   = (state_d == V_AL) || (state_d == E_AH) || (state_d == E_AM);
    assign inc_sel_d = (state_d == E_AH) || (state_d == E_AM);

    always_comb begin
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
`ifdef DISP_SNOOZE_EN
        snz_act_d  = snz_act_q;
        snz_cnt_d  = snz_cnt_q;
`endif
        if (!alarm_en) begin
            ring_d     = 1'b0;
            ring_cnt_d = '0;
`ifdef DISP_SNOOZE_EN
            snz_act_d  = 1'b0;
            snz_cnt_d  = '0;
`endif
        end else if (match) begin
            ring_d     = 1'b1;
            ring_cnt_d = RW'(RING_SECS);
`ifdef DISP_SNOOZE_EN
            snz_act_d  = 1'b0;
            snz_cnt_d  = '0;
`endif
        end else if (ring_q && key_any) begin
            ring_d     = 1'b0;
            ring_cnt_d = '0;
`ifdef DISP_SNOOZE_EN
            // A lone key_inc snoozes; any other key dismisses outright.
            snz_act_d  = key_inc && !key_mode && !key_set;
            snz_cnt_d  = snz_act_d ? SW_W'(SNOOZE_SECS) : '0;
`endif
        end else if (ring_q && tick_1hz) begin
            ring_cnt_d = ring_cnt_q - RW'(1);
            if (ring_cnt_q == RW'(1))
                ring_d = 1'b0;
        end
`ifdef DISP_SNOOZE_EN
        else if (snz_act_q && tick_1hz) begin
            snz_cnt_d = snz_cnt_q - SW_W'(1);
            if (snz_cnt_q == SW_W'(1)) begin
                snz_act_d  = 1'b0;
                ring_d     = 1'b1;
                ring_cnt_d = RW'(RING_SECS);
            end
        end
`endif
    end

    always_ff @(posedge signal or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= V_TIME;
            to_cnt_q     <= '0;
            ring_cnt_q   <= '0;
            ring_q       <= 1'b0;
            sw_q         <= 1'b0;
            alarm_q      <= 1'b0;
            inc_sel_q    <= 1'b0;
            sw_run_q     <= 1'b0;
            blink_q      <= 1'b0;
            inc_hour_q   <= 1'b0;
            inc_minute_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            ring_cnt_q   <= ring_cnt_d;
            ring_q       <= ring_d;
            sw_q         <= sw_d;
            alarm_q      <= alarm_d;
            inc_sel_q    <= inc_sel_d;
            sw_run_q     <= sw_run_d;
            blink_q      <= blink_d;
            inc_hour_q   <= inc_hour_d;
            inc_minute_q <= inc_minute_d;
        end
    end

`ifdef DISP_SNOOZE_EN
    always_ff @(posedge signal or negedge rst_n) begin
        if (!rst_n) begin
            snz_act_q <= 1'b0;
            snz_cnt_q <= '0;
        end else begin
            snz_act_q <= snz_act_d;
            snz_cnt_q <= snz_cnt_d;
        end
    end
`endif

    assign sw         = sw_q;
    assign alarm      = alarm_q;
    assign inc_sel    = inc_sel_q;
    assign sw_run     = sw_run_q;
    assign blink      = blink_q;
    assign inc_hour   = inc_hour_q;
    assign inc_minute = inc_minute_q;
    assign ring       = ring_q;
    assign state      = state_q;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Directed bench for disp_mode_ctrl: view cycling, edit pulses, edit timeout,
// alarm ring timing/cancel, stopwatch run flag and asynchronous reset.
module tb_disp_mode_ctrl;
    logic       signal = 1'b0;
    logic       rst_n;
    logic       key_mode, key_set, key_inc, tick_1hz, alarm_en;
    logic [4:0] hour_true, hour_al;
    logic [5:0] minute_true, second_true, minute_al;
    logic       sw, alarm, sw_run, inc_hour, inc_minute, inc_sel, blink, ring;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    localparam int M = 1, S = 2, I = 4, T = 8;

    disp_mode_ctrl dut (
        .signal(signal), .rst_n(rst_n),
        .key_mode(key_mode), .key_set(key_set), .key_inc(key_inc),
        .tick_1hz(tick_1hz), .alarm_en(alarm_en),
        .hour_true(hour_true), .minute_true(minute_true), .second_true(second_true),
        .hour_al(hour_al), .minute_al(minute_al),
        .sw(sw), .alarm(alarm), .sw_run(sw_run), .inc_hour(inc_hour),
        .inc_minute(inc_minute), .inc_sel(inc_sel), .blink(blink),
        .ring(ring), .state(state)
    );

    always #5 signal = ~signal;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive the selected one-cycle pulses across one posedge; returns at the
    // following negedge, where the registered response is visible.
    task automatic pulse(input int mask);
        @(negedge signal);
        key_mode = mask[0];
        key_set  = mask[1];
        key_inc  = mask[2];
        tick_1hz = mask[3];
        @(negedge signal);
        key_mode = 1'b0;
        key_set  = 1'b0;
        key_inc  = 1'b0;
        tick_1hz = 1'b0;
    endtask

    task automatic set_match_time(input logic en);
        alarm_en    = en;
        hour_al     = 5'd7;
        minute_al   = 6'd30;
        hour_true   = 5'd7;
        minute_true = 6'd30;
        second_true = 6'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        key_mode = 0; key_set = 0; key_inc = 0; tick_1hz = 0; alarm_en = 0;
        hour_true = 5'd0; minute_true = 6'd0; second_true = 6'd5;
        hour_al = 5'd12; minute_al = 6'd0;
        #12;
        check("rst_state", 8'(state), 8'd0);
        check("rst_sw", 8'(sw), 8'd0);
        check("rst_alarm", 8'(alarm), 8'd0);
        check("rst_ring", 8'(ring), 8'd0);
        check("rst_sw_run", 8'(sw_run), 8'd0);
        check("rst_blink", 8'(blink), 8'd0);
        check("rst_inc", 8'({inc_hour, inc_minute, inc_sel}), 8'd0);
        @(negedge signal);
        rst_n = 1'b1;

        // View cycling
        pulse(M);
        check("mode1_state", 8'(state), 8'd1);
        check("mode1_sel", 8'({sw, alarm}), 8'b10);
        pulse(M);
        check("mode2_state", 8'(state), 8'd2);
        check("mode2_sel", 8'({sw, alarm}), 8'b01);
        pulse(M);
        check("mode3_state", 8'(state), 8'd0);
        check("mode3_sel", 8'({sw, alarm}), 8'b00);

        // Alarm edit sequence
        pulse(M); pulse(M);
        pulse(S);
        check("eah_state", 8'(state), 8'd5);
        check("eah_sel", 8'({alarm, inc_sel}), 8'b11);
        check("eah_blink", 8'(blink), 8'd1);
        pulse(I);
        check("inc_h1", 8'({inc_hour, inc_minute}), 8'b10);
        @(negedge signal);
        check("inc_h1_end", 8'({inc_hour, inc_minute}), 8'b00);
        pulse(I);
        check("inc_h2", 8'({inc_hour, inc_minute}), 8'b10);
        pulse(S);
        check("eam_state", 8'(state), 8'd6);
        check("eam_incsel", 8'(inc_sel), 8'd1);
        check("eam_noinc", 8'({inc_hour, inc_minute}), 8'b00);
        pulse(I);
        check("inc_m1", 8'({inc_hour, inc_minute}), 8'b01);
        @(negedge signal);
        check("inc_m1_end", 8'({inc_hour, inc_minute}), 8'b00);
        pulse(S);
        check("eam_exit", 8'(state), 8'd2);
        check("eam_exit_sel", 8'({alarm, inc_sel, blink}), 8'b100);
        pulse(I);
        check("val_inc_ign", 8'({inc_hour, inc_minute, state}), 8'd2);
        pulse(M);
        check("back_vtime", 8'(state), 8'd0);

        // Edit timeout with blink toggling
        pulse(S);
        check("eth_state", 8'(state), 8'd3);
        check("eth_blink0", 8'(blink), 8'd1);
        for (int k = 1; k <= 10; k++) begin
            pulse(T);
            if (k < 10) begin
                check($sformatf("to_state_%0d", k), 8'(state), 8'd3);
                check($sformatf("to_blink_%0d", k), 8'(blink), (k % 2 == 0) ? 8'd1 : 8'd0);
            end else begin
                check("to_state_10", 8'(state), 8'd0);
                check("to_blink_10", 8'(blink), 8'd0);
            end
        end

        // Ring lasts exactly 30 ticks
        set_match_time(1'b1);
        pulse(T);
        check("ring_on", 8'(ring), 8'd1);
        second_true = 6'd1;
        for (int k = 1; k <= 30; k++) begin
            pulse(T);
            if (k == 29 || k == 30 || k == 1)
                check($sformatf("ring_tick_%0d", k), 8'(ring), (k < 30) ? 8'd1 : 8'd0);
        end

        // Disarmed alarm never rings
        set_match_time(1'b0);
        pulse(T);
        check("ring_disarmed", 8'(ring), 8'd0);

        // Key cancels ring without state change
        set_match_time(1'b1);
        pulse(T);
        check("ring_on2", 8'(ring), 8'd1);
        second_true = 6'd2;
        pulse(M);
        check("cancel_ring", 8'(ring), 8'd0);
        check("cancel_state", 8'(state), 8'd0);

        // Match coincident with key_set: match wins
        second_true = 6'd0;
        pulse(T | S);
        check("coinc_ring", 8'(ring), 8'd1);
        check("coinc_state", 8'(state), 8'd0);
        second_true = 6'd3;

        // Disarm clears ring within one cycle
        @(negedge signal);
        alarm_en = 1'b0;
        @(negedge signal);
        check("disarm_ring", 8'(ring), 8'd0);
        alarm_en = 1'b1;

        // Stopwatch run persists outside V_SW
        pulse(M);
        check("vsw_state", 8'(state), 8'd1);
        pulse(I);
        check("sw_run_on", 8'(sw_run), 8'd1);
        pulse(M); pulse(M);
        check("sw_run_bg_state", 8'(state), 8'd0);
        check("sw_run_bg", 8'(sw_run), 8'd1);

        // Asynchronous reset mid-ring
        second_true = 6'd0;
        pulse(T);
        check("ring_on3", 8'(ring), 8'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ring", 8'(ring), 8'd0);
        check("arst_sw_run", 8'(sw_run), 8'd0);
        check("arst_state", 8'(state), 8'd0);
        @(negedge signal);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/disp_mode_ctrl.md
Name: disp_mode_ctrl

Overview:
- Front-panel sequencer for the electronic clock.
- Turns debounced key pulses into the `sw`/`alarm` view selects consumed by the display mux.
- Drives edit pulses into the true-time and alarm counters, and runs stopwatch start/stop.
- Detects the alarm match and times the ring output. Sits between the key debouncers and the time/stopwatch/alarm counters.

Parameters:
- RING_SECS, 30: seconds the ring output stays asserted after an alarm match.
- EDIT_TIMEOUT, 10: seconds without a key press before an edit state aborts back to its view state.
- SNOOZE_SECS, 300: snooze delay in seconds (used only with the optional feature).

Ports:
- signal  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_mode  in  1  one-cycle pulse; cycles between view states.
- key_set  in  1  one-cycle pulse; enters or advances edit.
- key_inc  in  1  one-cycle pulse; increments the edited field; start/stop in stopwatch view.
- tick_1hz  in  1  one-cycle pulse, once per second.
- alarm_en  in  1  level; alarm armed.
- hour_true  in  5  current hour, 0-23.
- minute_true  in  6  current minute.
- second_true  in  6  current second.
- hour_al  in  5  alarm hour.
- minute_al  in  6  alarm minute.
- sw  out  1  stopwatch view select.
- alarm  out  1  alarm view select.
- sw_run  out  1  stopwatch run enable.
- inc_hour  out  1  one-cycle hour increment pulse.
- inc_minute  out  1  one-cycle minute increment pulse.
- inc_sel  out  1  increment target: 0 = true-time counter, 1 = alarm register.
- blink  out  1  field-blink enable; high in edit states, toggles on each tick_1hz.
- ring  out  1  buzzer enable.
- state  out  3  current FSM state code.

Behaviour:
- Reset: all outputs registered; every output is 0 on reset; FSM in V_TIME; all counters cleared.
- Timing: all outputs update on the posedge of signal; selects and pulses appear 1 cycle after the input pulse.

State encodings and outputs:
- V_TIME = 0: sw=0, alarm=0.
- V_SW = 1: sw=1, alarm=0.
- V_AL = 2: sw=0, alarm=1.
- E_TH = 3: edit true hour; sw=0, alarm=0, inc_sel=0.
- E_TM = 4: edit true minute; sw=0, alarm=0, inc_sel=0.
- E_AH = 5: edit alarm hour; sw=0, alarm=1, inc_sel=1.
- E_AM = 6: edit alarm minute; sw=0, alarm=1, inc_sel=1.
- Code 7 is unused and returns to V_TIME on the next clock.

Transitions:
- key_mode: V_TIME -> V_SW -> V_AL -> V_TIME. In any edit state key_mode aborts to that state's view (E_Tx -> V_TIME, E_Ax -> V_AL).
- key_set: V_TIME -> E_TH -> E_TM -> V_TIME; V_AL -> E_AH -> E_AM -> V_AL; ignored in V_SW.
- key_inc:
  - E_TH/E_AH: inc_hour pulse for 1 cycle.
  - E_TM/E_AM: inc_minute pulse for 1 cycle.
  - V_SW: toggles sw_run.
  - Ignored in V_TIME and V_AL.
- sw_run keeps its value when leaving V_SW; the stopwatch keeps running in the background.

Edit timeout:
- Seconds counter is cleared on any key pulse and on entry to an edit state; increments on tick_1hz while in an edit state.
- When it reaches EDIT_TIMEOUT: transition to the view state, as for key_mode.
- blink is 0 outside edit states.

Alarm:
- Match = alarm_en & hour_true==hour_al & minute_true==minute_al & second_true==0 & tick_1hz.
- On match: ring=1 and the ring counter loads RING_SECS; the counter decrements on tick_1hz; ring drops when it reaches 0.
- Deasserting alarm_en clears ring within 1 cycle.
- Ring does not change the FSM state.

Simultaneous events:
- Priority: cancel-ring > key_mode > key_set > key_inc.
- Any key pulse while ring=1 only cancels the ring (ring=0 next cycle); the pulse is consumed, with no state change and no inc.
- A match in the same cycle as a key pulse: the match wins; ring=1 and the key is consumed.

Reset mid-operation:
- Asserting rst_n low during ring or edit clears ring, sw_run and inc pulses immediately (asynchronous) and returns the FSM to V_TIME.

Optional Feature:
- Macro: DISP_SNOOZE_EN.
- Defined:
  - key_inc during ring cancels the ring and loads a snooze counter with SNOOZE_SECS; the counter decrements on tick_1hz.
  - At 0 the ring re-asserts for RING_SECS, independent of the time match.
  - Any other key during ring, or alarm_en=0, cancels both ring and snooze.
- Undefined: no snooze logic; key_inc cancels the ring like any other key.

Test Plan:
- Reset, then key_mode x3 -> state 0->1->2->0, with (sw,alarm) = (0,0), (1,0), (0,1), (0,0).
- V_AL, key_set, key_inc x2, key_set, key_inc, key_set -> state 5, then 6, then 2; inc_sel=1; two 1-cycle inc_hour pulses, then one inc_minute pulse.
- V_TIME, key_set, then 10 tick_1hz with no keys -> state returns to 0 on the 10th tick; blink toggles each tick while in E_TH.
- alarm_en=1, al=07:30, time 07:30:00 with tick -> ring=1 for exactly 30 ticks, then 0; the same setup with alarm_en=0 -> ring stays 0.
- ring=1 and key_mode pulse -> ring=0 next cycle, state unchanged. Match coincident with key_set -> ring=1, state unchanged.
- V_SW, key_inc -> sw_run=1; key_mode to V_TIME -> sw_run still 1. rst_n low mid-ring -> ring=0, sw_run=0, state=0 with no clock edge.
